// File: rtl/ct_ciu_snb_pkg.sv
// Shared constants and controller state encoding for the snoop-buffer age arbiter.
package ct_ciu_snb_pkg;

   localparam int SNB_DEPTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } snb_arb_state_e;

endpackage

// File: rtl/ct_ciu_snb_age_mtx.sv
// Age matrix for the snoop buffer: age[i][j]=1 means entry j is older than entry i.
// The diagonal is never set.
module ct_ciu_snb_age_mtx
   import ct_ciu_snb_pkg::*;
#(
   parameter int DEPTH = SNB_DEPTH,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic                        forever_cpuclk,
   input  logic                        cpurst,
   input  logic                        alloc_vld,
   input  logic [IDXW-1:0]             alloc_idx,
   input  logic [DEPTH-1:0]            entry_vld,
   input  logic [DEPTH-1:0]            dealloc,
   output logic [DEPTH-1:0][DEPTH-1:0] age
);

   logic [DEPTH-1:0] alloc_oh;

   assign alloc_oh = alloc_vld ? (DEPTH'(1) << alloc_idx) : '0;

   // New entry sees every surviving entry as older; nobody sees it as older.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         age <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) age[i] <= entry_vld & ~dealloc & ~alloc_oh;
            else             age[i] <= age[i] & ~alloc_oh;
         end
      end
   end

endmodule

// File: rtl/ct_ciu_snb_age_arb.sv
// Oldest-first arbiter for snoop-buffer entries with a registered offer/handshake port.
// Optional accepted-grant counter enabled by CT_CIU_SNB_ARB_PERF_EN.
//
//   state | meaning
//   IDLE  | nothing offered; sel/sel_idx are zero
//   OFFER | sel holds the offered entry until accepted or no longer eligible
module ct_ciu_snb_age_arb
   import ct_ciu_snb_pkg::*;
#(
   parameter int DEPTH = SNB_DEPTH,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             alloc_vld,
   input  logic [IDXW-1:0]  alloc_idx,
   input  logic [DEPTH-1:0] dealloc,
   input  logic [DEPTH-1:0] req_vld,
   input  logic             gnt_rdy,
   output logic [DEPTH-1:0] sel,
   output logic             sel_vld,
   output logic [IDXW-1:0]  sel_idx,
   output logic [DEPTH-1:0] entry_vld,
   output logic [15:0]      perf_gnt_cnt
);

   snb_arb_state_e             state, state_nxt;
   logic [DEPTH-1:0][DEPTH-1:0] age;
   logic [DEPTH-1:0]           alloc_oh;
   logic [DEPTH-1:0]           mask, mask_nxt;
   logic [DEPTH-1:0]           elig, elig_g, cand, cand_g, sel_nxt;
   logic [IDXW-1:0]            idx_nxt;

   assign alloc_oh = alloc_vld ? (DEPTH'(1) << alloc_idx) : '0;

   // Alloc wins over a same-cycle dealloc of the same entry.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) entry_vld <= '0;
      else        entry_vld <= (entry_vld & ~dealloc) | alloc_oh;
   end

   ct_ciu_snb_age_mtx #(
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
   ) u_mtx (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .alloc_vld      (alloc_vld),
      .alloc_idx      (alloc_idx),
      .entry_vld      (entry_vld),
      .dealloc        (dealloc),
      .age            (age)
   );

   // elig_g drops the entry being accepted so back-to-back grants never repeat it.
   assign elig   = req_vld & entry_vld & ~mask;
   assign elig_g = elig & ~sel;

   always_comb begin
      cand   = '0;
      cand_g = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand[i]   = elig[i]   & ~|(elig   & age[i]);
         cand_g[i] = elig_g[i] & ~|(elig_g & age[i]);
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      mask_nxt  = '0;
      case (state)
         IDLE: begin
            if (|elig) begin
               state_nxt = OFFER;
               sel_nxt   = cand;
            end
         end
         OFFER: begin
            if (gnt_rdy) begin
               mask_nxt  = sel;
               sel_nxt   = cand_g;
               state_nxt = (|elig_g) ? OFFER : IDLE;
            end else if (~|(sel & elig & ~dealloc)) begin
               state_nxt = IDLE;
               sel_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            sel_nxt   = '0;
         end
      endcase
      idx_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel_nxt[i]) idx_nxt = IDXW'(i);
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state   <= IDLE;
         sel     <= '0;
         sel_idx <= '0;
         mask    <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         sel_idx <= idx_nxt;
         mask    <= mask_nxt;
      end
   end

   assign sel_vld = (state == OFFER);

`ifdef CT_CIU_SNB_ARB_PERF_EN
   logic [15:0] perf_q;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst)                                        perf_q <= '0;
      else if (sel_vld && gnt_rdy && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
   end

   assign perf_gnt_cnt = perf_q;
`else
   assign perf_gnt_cnt = '0;
`endif

   // Re-allocating a live entry without releasing it corrupts the age order.
   assert property (@(posedge forever_cpuclk) disable iff (cpurst)
      alloc_vld |-> (!entry_vld[alloc_idx] || dealloc[alloc_idx]))
      else $error("alloc to live entry %0d", alloc_idx);

endmodule

// File: tb/tb_ct_ciu_snb_age_arb.sv
// Directed and random checks of the snoop-buffer age arbiter against an
// allocation-order queue model.
module tb_ct_ciu_snb_age_arb;

   localparam int DEPTH = 8;
   localparam int IDXW  = 3;

   logic             forever_cpuclk = 1'b0;
   logic             cpurst;
   logic             alloc_vld;
   logic [IDXW-1:0]  alloc_idx;
   logic [DEPTH-1:0] dealloc;
   logic [DEPTH-1:0] req_vld;
   logic             gnt_rdy;
   logic [DEPTH-1:0] sel;
   logic             sel_vld;
   logic [IDXW-1:0]  sel_idx;
   logic [DEPTH-1:0] entry_vld;
   logic [15:0]      perf_gnt_cnt;

   int checks   = 0;
   int failures = 0;

   // Model: allocation order (oldest first), valid set, offered entry, masked entry.
   int order[$];
   bit mvld[DEPTH];
   int moff;
   int mmask;
   int mgnt;

   always #5 forever_cpuclk = ~forever_cpuclk;

   ct_ciu_snb_age_arb #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .alloc_vld      (alloc_vld),
      .alloc_idx      (alloc_idx),
      .dealloc        (dealloc),
      .req_vld        (req_vld),
      .gnt_rdy        (gnt_rdy),
      .sel            (sel),
      .sel_vld        (sel_vld),
      .sel_idx        (sel_idx),
      .entry_vld      (entry_vld),
      .perf_gnt_cnt   (perf_gnt_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int oldest(input bit el[DEPTH]);
      foreach (order[k]) if (el[order[k]]) return order[k];
      return -1;
   endfunction

   task automatic drop(input int e);
      for (int k = 0; k < order.size(); k++) begin
         if (order[k] == e) begin
            order.delete(k);
            break;
         end
      end
   endtask

   task automatic model_reset();
      order.delete();
      for (int e = 0; e < DEPTH; e++) mvld[e] = 1'b0;
      moff  = -1;
      mmask = -1;
      mgnt  = 0;
   endtask

   task automatic model_step();
      bit el[DEPTH];
      int nxt;
      int nmask;
      for (int e = 0; e < DEPTH; e++) el[e] = req_vld[e] && mvld[e] && (e != mmask);
      nmask = -1;
      if (moff < 0) begin
         nxt = oldest(el);
      end else if (gnt_rdy) begin
         mgnt++;
         el[moff] = 1'b0;
         nmask    = moff;
         nxt      = oldest(el);
      end else begin
         nxt = (el[moff] && !dealloc[moff]) ? moff : -1;
      end
      for (int e = 0; e < DEPTH; e++) begin
         if (dealloc[e]) begin
            mvld[e] = 1'b0;
            drop(e);
         end
      end
      if (alloc_vld) begin
         drop(int'(alloc_idx));
         order.push_back(int'(alloc_idx));
         mvld[alloc_idx] = 1'b1;
      end
      moff  = nxt;
      mmask = nmask;
   endtask

   task automatic check_all(input string tag);
      logic [DEPTH-1:0] ent;
      logic [15:0]      pexp;
      for (int e = 0; e < DEPTH; e++) ent[e] = mvld[e];
`ifdef CT_CIU_SNB_ARB_PERF_EN
      pexp = (mgnt > 65535) ? 16'hFFFF : 16'(mgnt);
`else
      pexp = 16'h0;
`endif
      chk({tag, "_vld"},  32'(sel_vld),   32'(moff >= 0));
      chk({tag, "_sel"},  32'(sel),       (moff >= 0) ? (32'd1 << moff) : 32'd0);
      chk({tag, "_idx"},  32'(sel_idx),   (moff >= 0) ? 32'(moff) : 32'd0);
      chk({tag, "_ent"},  32'(entry_vld), 32'(ent));
      chk({tag, "_perf"}, 32'(perf_gnt_cnt), 32'(pexp));
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge forever_cpuclk);
      #1;
      check_all(tag);
   endtask

   // Requester drops the request of an accepted entry right after the handshake.
   task automatic gcycle(input string tag);
      int g;
      g = (moff >= 0 && gnt_rdy) ? moff : -1;
      cycle(tag);
      if (g >= 0) req_vld[g] = 1'b0;
   endtask

   task automatic alloc(input int e);
      alloc_vld = 1'b1;
      alloc_idx = IDXW'(e);
      cycle("alloc");
      alloc_vld = 1'b0;
   endtask

   task automatic do_reset();
      cpurst    = 1'b1;
      alloc_vld = 1'b0;
      alloc_idx = '0;
      dealloc   = '0;
      req_vld   = '0;
      gnt_rdy   = 1'b0;
      @(posedge forever_cpuclk);
      @(posedge forever_cpuclk);
      #1;
      cpurst = 1'b0;
      model_reset();
      check_all("rst");
   endtask

   initial begin
      int a;
      do_reset();

      // Grants in age order, back to back, then idle.
      alloc(3); alloc(1); alloc(6);
      req_vld = 8'h4A; gnt_rdy = 1'b1;
      gcycle("r32a"); chk("r32_first", 32'(sel), 32'h08);
      gcycle("r32b"); chk("r32_second", 32'(sel), 32'h02);
      gcycle("r32c"); chk("r32_third", 32'(sel), 32'h40);
      gcycle("r32d"); chk("r32_idle", 32'(sel_vld), 32'h0);

      // Offer holds while not accepted.
      do_reset();
      alloc(3);
      req_vld = 8'h08; gnt_rdy = 1'b0;
      cycle("r33a");
      alloc_vld = 1'b1; alloc_idx = 3'd0; req_vld = 8'h09;
      cycle("r33b");
      alloc_vld = 1'b0;
      cycle("r33c"); chk("r33_hold", 32'(sel), 32'h08);
      gnt_rdy = 1'b1;
      gcycle("r33d"); chk("r33_next", 32'(sel), 32'h01);
      gnt_rdy = 1'b0;

      // Held offer revoked on dealloc; older survivor offered after.
      do_reset();
      alloc(2); alloc(5);
      req_vld = 8'h20;
      cycle("r34a"); chk("r34_offer", 32'(sel), 32'h20);
      req_vld = 8'h24;
      cycle("r34b"); chk("r34_hold", 32'(sel), 32'h20);
      dealloc = 8'h20;
      cycle("r34c"); chk("r34_revoke", 32'(sel_vld), 32'h0);
      dealloc = 8'h00;
      cycle("r34d"); chk("r34_survivor", 32'(sel), 32'h04);

      // Same-cycle alloc/dealloc of an entry.
      do_reset();
      alloc(4); alloc(2); alloc(7);
      alloc_vld = 1'b1; alloc_idx = 3'd2; dealloc = 8'h14;
      cycle("r35a");
      alloc_vld = 1'b0; dealloc = 8'h00;
      chk("r35_row2", 32'(dut.u_mtx.age[2]), 32'h80);
      chk("r35_age7_2", 32'(dut.u_mtx.age[7][2]), 32'h0);
      req_vld = 8'h84;
      cycle("r35b"); chk("r35_oldest", 32'(sel), 32'h80);

      // Asynchronous reset mid-offer, then first alloc right after release.
      do_reset();
      alloc(1);
      req_vld = 8'h02;
      cycle("r36a");
      #3 cpurst = 1'b1;
      #1;
      chk("async_vld", 32'(sel_vld), 32'h0);
      chk("async_sel", 32'(sel), 32'h0);
      chk("async_idx", 32'(sel_idx), 32'h0);
      chk("async_ent", 32'(entry_vld), 32'h0);
      chk("async_perf", 32'(perf_gnt_cnt), 32'h0);
      req_vld = '0;
      @(posedge forever_cpuclk);
      #1;
      cpurst = 1'b0;
      model_reset();
      alloc(5);
      chk("first_alloc", 32'(entry_vld), 32'h20);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         dealloc = '0;
         for (int e = 0; e < DEPTH; e++)
            if (mvld[e] && $urandom_range(0, 9) == 0) dealloc[e] = 1'b1;
         a = $urandom_range(0, DEPTH - 1);
         alloc_vld = ($urandom_range(0, 2) == 0) && (!mvld[a] || dealloc[a]);
         alloc_idx = a[IDXW-1:0];
         if ($urandom_range(0, 3) == 0) req_vld = DEPTH'($urandom);
         gnt_rdy = 1'($urandom_range(0, 1));
         cycle("rnd");
      end

`ifdef CT_CIU_SNB_ARB_PERF_EN
      // Three rotating requesters give one grant per cycle; counter must saturate.
      do_reset();
      alloc(0); alloc(1); alloc(2);
      req_vld = 8'h07; gnt_rdy = 1'b1;
      for (int c = 0; c < 70005; c++) begin
         model_step();
         @(posedge forever_cpuclk);
         #1;
      end
      check_all("perf");
      chk("perf_sat", 32'(perf_gnt_cnt), 32'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
